dmem_store_buffer: RTL and testbench

Posted-write store buffer between the CPU's MEM-stage data port and a single-port backing data memory whose write side may take several cycles. Stores retire from the CPU in one cycle into a DEPTH-entry FIFO. The FIFO drains to memory through a valid/ready write handshake whenever the port is not claimed by a load. Loads read memory combinationally, with youngest-match forwarding from buffered stores, so the CPU's one-cycle MEM-stage timing is preserved.

---
 rtl/dmem_store_buffer.sv | 225 ++++++++++++++++++++++
 tb/tb_dmem_store_buffer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer
//   Posted-write store buffer between the CPU MEM-stage data port and a
//   single-port backing memory. Stores retire into a DEPTH-entry FIFO in one
//   cycle. The FIFO drains through a valid/ready write handshake whenever no
//   load owns the port. Loads read memory combinationally. A buffered store to
//   the same doubleword forwards its data, and the youngest such store wins.
//
//   Optional feature macro: SB_COALESCE_EN
//     When defined, a store to the same doubleword as the youngest entry
//     overwrites that entry's data in place. This happens only when that entry
//     is not the head.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   cpu_addr/cpu_wdata  MEM-stage address / store data
//   cpu_memwrite        store this cycle
//   cpu_memread         load this cycle
//   cpu_rdata           load data (combinational, forwarded or mem_rdata)
//   mem_addr/mem_re     backing-memory address / read strobe
//   mem_rdata           backing read data (combinational from mem_addr)
//   mem_wdata           head-entry data
//   mem_wvalid          head entry offered for write
//   mem_wready          memory accepts the write
//   sb_count            occupied entries
//   sb_full/sb_empty    occupancy flags
//   cpu_stall_req       same as sb_full
//   overflow_err        sticky; set when a store is dropped
module dmem_store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ADDR_W-1:0]        cpu_addr,
    input  logic [DATA_W-1:0]        cpu_wdata,
    input  logic                     cpu_memwrite,
    input  logic                     cpu_memread,
    output logic [DATA_W-1:0]        cpu_rdata,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic                     mem_re,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic [DATA_W-1:0]        mem_wdata,
    output logic                     mem_wvalid,
    input  logic                     mem_wready,
    output logic [$clog2(DEPTH):0]   sb_count,
    output logic                     sb_full,
    output logic                     sb_empty,
    output logic                     cpu_stall_req,
    output logic                     overflow_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(1'b0);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    logic [ADDR_W-1:0] addr_mem_q [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    state_t            state_q, state_d;

    logic              full_s, wvalid_s, pop_s, coal_s, push_s, drop_s;
    logic [DEPTH-1:0]  hit_vec_s;
    logic              fwd_hit_s;
    logic [PTR_W-1:0]  fwd_sel_s;

    // Addresses refer to the same doubleword when they agree above bit 2.
    function automatic logic dw_match(input logic [ADDR_W-1:0] a,
                                      input logic [ADDR_W-1:0] b);
        return a[ADDR_W-1:3] == b[ADDR_W-1:3];
    endfunction

    assign full_s = (count_q == CNT_FULL);

    // Port arbitration: a load claims the address bus and suppresses the write offer.
    always_comb begin
        mem_addr = addr_mem_q[head_q];
        wvalid_s = 1'b0;
        if (cpu_memread) begin
            mem_addr = cpu_addr;
            wvalid_s = 1'b0;
        end else begin
            mem_addr = addr_mem_q[head_q];
            wvalid_s = (state_q == ST_DRAIN);
        end
    end

    assign pop_s = wvalid_s & mem_wready;

`ifdef SB_COALESCE_EN
    logic [PTR_W-1:0] young_s;
    assign young_s = tail_q - PTR_ONE;
    // Merge into the youngest entry only when at least two entries exist.
    // With two or more entries, the youngest entry cannot be the head, which
    // may be committing this cycle.
    assign coal_s = cpu_memwrite && (count_q >= CNT_W'(2'd2))
                    && dw_match(cpu_addr, addr_mem_q[young_s]);
`else
    assign coal_s = 1'b0;
`endif

    // A full buffer still accepts a store when the head leaves on the same edge.
    assign push_s = cpu_memwrite && !coal_s && (!full_s || pop_s);
    assign drop_s = cpu_memwrite && !coal_s && full_s && !pop_s;

    // Per-entry forwarding hit: occupied slot at offset i from head, same doubleword.
    always_comb begin
        hit_vec_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_vec_s[i] = (CNT_W'(i) < count_q)
                           && dw_match(cpu_addr, addr_mem_q[head_q + PTR_W'(i)]);
        end
    end

    // Youngest-match select: later offsets from head are younger and override.
    always_comb begin
        fwd_hit_s = 1'b0;
        fwd_sel_s = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_hit_s = fwd_hit_s | hit_vec_s[i];
            fwd_sel_s = hit_vec_s[i] ? (head_q + PTR_W'(i)) : fwd_sel_s;
        end
        cpu_rdata = fwd_hit_s ? data_mem_q[fwd_sel_s] : mem_rdata;
    end

    // Pointer, occupancy and sticky-error next state.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (pop_s) begin
            head_d = head_q + PTR_ONE;
        end else begin
            head_d = head_q;
        end
        if (push_s) begin
            tail_d = tail_q + PTR_ONE;
        end else begin
            tail_d = tail_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        if (drop_s) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Drain FSM next state: leave DRAIN once the final entry pops with no refill.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (push_s) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (count_d == CNT_ZERO) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control state registers; reset discards every buffered store at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            state_q    <= ST_IDLE;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
        end
    end

    // Entry storage. It is not cleared on reset because the pointers define occupancy.
    always_ff @(posedge clk) begin
        if (push_s) begin
            addr_mem_q[tail_q] <= cpu_addr;
            data_mem_q[tail_q] <= cpu_wdata;
        end
`ifdef SB_COALESCE_EN
        else if (coal_s) begin
            data_mem_q[young_s] <= cpu_wdata;
        end
`endif
    end

    assign mem_re        = cpu_memread;
    assign mem_wdata     = data_mem_q[head_q];
    assign mem_wvalid    = wvalid_s;
    assign sb_count      = count_q;
    assign sb_full       = full_s;
    assign sb_empty      = (count_q == CNT_ZERO);
    assign cpu_stall_req = full_s;
    assign overflow_err  = overflow_q;

endmodule

// File: tb/tb_dmem_store_buffer.sv
module tb_dmem_store_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 64;
    localparam int DW    = 64;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [AW-1:0]          cpu_addr = '0;
    logic [DW-1:0]          cpu_wdata = '0;
    logic                   cpu_memwrite = 1'b0;
    logic                   cpu_memread = 1'b0;
    logic [DW-1:0]          cpu_rdata;
    logic [AW-1:0]          mem_addr;
    logic                   mem_re;
    logic [DW-1:0]          mem_rdata = '0;
    logic [DW-1:0]          mem_wdata;
    logic                   mem_wvalid;
    logic                   mem_wready = 1'b0;
    logic [$clog2(DEPTH):0] sb_count;
    logic                   sb_full, sb_empty, cpu_stall_req, overflow_err;

    dmem_store_buffer #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_memwrite(cpu_memwrite), .cpu_memread(cpu_memread),
        .cpu_rdata(cpu_rdata), .mem_addr(mem_addr), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .mem_wvalid(mem_wvalid),
        .mem_wready(mem_wready), .sb_count(sb_count), .sb_full(sb_full),
        .sb_empty(sb_empty), .cpu_stall_req(cpu_stall_req),
        .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    typedef struct {
        int            cnt;
        bit            ovf;
        bit            wv;
        bit            re;
        bit            chk_a;
        logic [AW-1:0] ma;
        logic [DW-1:0] wd;
    } st_t;

    // Reference model: an ordered list of pending stores (oldest first).
    ent_t          m_q[$];
    bit            m_ovf = 1'b0;

    // Scoreboard queues filled by stimulus and drained by the monitor.
    st_t           st_q[$];
    ent_t          wr_q[$];
    logic [DW-1:0] ld_q[$];

    int n_vec = 0;
    int n_err = 0;

    function automatic bit same_dw(input logic [AW-1:0] a, input logic [AW-1:0] b);
        return (a >> 3) == (b >> 3);
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        st_t st;
        @(negedge clk);
        rst_n        = 1'b0;
        cpu_memwrite = 1'b0;
        cpu_memread  = 1'b0;
        mem_wready   = 1'b0;
        m_q.delete();
        m_ovf  = 1'b0;
        st.cnt = 0; st.ovf = 1'b0; st.wv = 1'b0; st.re = 1'b0; st.chk_a = 1'b0;
        st.ma  = '0; st.wd = '0;
        st_q.push_back(st);
    endtask

    task automatic do_cycle(input bit wr, input bit rd, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input bit wrdy,
                            input logic [DW-1:0] mrd);
        st_t           st;
        logic [DW-1:0] exp_ld;
        bit            pop;
        bit            coal;
        int            n;
        ent_t          e;
        @(negedge clk);
        rst_n        = 1'b1;
        cpu_memwrite = wr;
        cpu_memread  = rd;
        cpu_addr     = a;
        cpu_wdata    = d;
        mem_wready   = wrdy;
        mem_rdata    = mrd;

        n        = m_q.size();
        st.cnt   = n;
        st.ovf   = m_ovf;
        st.re    = rd;
        st.wv    = !rd && (n > 0);
        st.chk_a = rd || (n > 0);
        st.ma    = rd ? a : ((n > 0) ? m_q[0].a : '0);
        st.wd    = (n > 0) ? m_q[0].d : '0;
        st_q.push_back(st);

        if (rd) begin
            exp_ld = mrd;
            for (int i = n - 1; i >= 0; i--) begin
                if (same_dw(m_q[i].a, a)) begin
                    exp_ld = m_q[i].d;
                    break;
                end
            end
            ld_q.push_back(exp_ld);
        end

        pop  = st.wv && wrdy;
        coal = 1'b0;
`ifdef SB_COALESCE_EN
        if (wr && n >= 2 && same_dw(m_q[n-1].a, a)) begin
            coal = 1'b1;
            e    = m_q[n-1];
            e.d  = d;
            m_q[n-1] = e;
        end
`endif
        if (pop) begin
            wr_q.push_back(m_q[0]);
            void'(m_q.pop_front());
        end
        if (wr && !coal) begin
            if (m_q.size() < DEPTH) begin
                e.a = a;
                e.d = d;
                m_q.push_back(e);
            end else begin
                m_ovf = 1'b1;
            end
        end
    endtask

    // Monitor: compares status every cycle, plus each write handshake and load.
    initial begin
        st_t           st;
        ent_t          e;
        logic [DW-1:0] x;
        forever begin
            @(negedge clk);
            #2;
            if (st_q.size() > 0) begin
                st = st_q.pop_front();
                check("sb_count", 128'(sb_count), 128'(st.cnt));
                check("sb_full", 128'(sb_full), 128'(st.cnt == DEPTH));
                check("sb_empty", 128'(sb_empty), 128'(st.cnt == 0));
                check("cpu_stall_req", 128'(cpu_stall_req), 128'(st.cnt == DEPTH));
                check("overflow_err", 128'(overflow_err), 128'(st.ovf));
                check("mem_wvalid", 128'(mem_wvalid), 128'(st.wv));
                check("mem_re", 128'(mem_re), 128'(st.re));
                if (st.chk_a) check("mem_addr", 128'(mem_addr), 128'(st.ma));
                if (st.wv)    check("mem_wdata", 128'(mem_wdata), 128'(st.wd));
            end
            if (mem_wvalid && mem_wready) begin
                if (wr_q.size() == 0) begin
                    check("unexpected_write", 128'(1'b1), 128'(1'b0));
                end else begin
                    e = wr_q.pop_front();
                    check("write_addr", 128'(mem_addr), 128'(e.a));
                    check("write_data", 128'(mem_wdata), 128'(e.d));
                end
            end
            if (cpu_memread && rst_n) begin
                if (ld_q.size() == 0) begin
                    check("unexpected_load", 128'(1'b1), 128'(1'b0));
                end else begin
                    x = ld_q.pop_front();
                    check("cpu_rdata", 128'(cpu_rdata), 128'(x));
                end
            end
        end
    end

    function automatic logic [AW-1:0] rnd_addr();
        logic [AW-1:0] a;
        a = 64'($urandom_range(0, 7)) << 3;
        a[2:0] = 3'($urandom);
        if ($urandom_range(0, 3) == 0) a[40] = 1'b1;
        return a;
    endfunction

    initial begin
        do_reset();
        // Single store drains on the next cycle, then the buffer is empty again.
        do_cycle(1'b1, 1'b0, 64'h100, 64'h11, 1'b1, 64'h0);
        do_cycle(1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 64'h0);
        do_cycle(1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 64'h0);
        // Fill with memory stalled, then drop a fifth store.
        for (int i = 0; i < DEPTH; i++)
            do_cycle(1'b1, 1'b0, 64'(i * 8), 64'(i + 1), 1'b0, 64'h0);
        do_cycle(1'b1, 1'b0, 64'h20, 64'h5, 1'b0, 64'h0);
        do_cycle(1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 64'h0);
        // Full with a pop on the same edge: the store is accepted.
        do_reset();
        for (int i = 0; i < DEPTH; i++)
            do_cycle(1'b1, 1'b0, 64'(i * 8), 64'(i + 16), 1'b0, 64'h0);
        do_cycle(1'b1, 1'b0, 64'h28, 64'h6, 1'b1, 64'h0);
        do_cycle(1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 64'h0);
        // Youngest-match forwarding, then back-to-back loads holding off the drain.
        do_reset();
        do_cycle(1'b1, 1'b0, 64'h40, 64'hAA, 1'b0, 64'h0);
        do_cycle(1'b1, 1'b0, 64'h40, 64'hBB, 1'b0, 64'h0);
        do_cycle(1'b0, 1'b1, 64'h40, 64'h0, 1'b0, 64'h0);
        do_cycle(1'b0, 1'b1, 64'h44, 64'h0, 1'b1, 64'h5A5A);
        do_cycle(1'b0, 1'b1, 64'h80, 64'h0, 1'b1, 64'h1234);
        do_cycle(1'b1, 1'b1, 64'h40, 64'hCC, 1'b1, 64'h77);
        for (int i = 0; i < 5; i++)
            do_cycle(1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 64'h0);
        // Store sequence with repeated doubleword (merges when coalescing is built in).
        do_reset();
        do_cycle(1'b1, 1'b0, 64'h0, 64'h1, 1'b0, 64'h0);
        do_cycle(1'b1, 1'b0, 64'h8, 64'h2, 1'b0, 64'h0);
        do_cycle(1'b1, 1'b0, 64'h8, 64'h3, 1'b0, 64'h0);
        for (int i = 0; i < 4; i++)
            do_cycle(1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 64'h0);
        // Randomized traffic with occasional mid-drain resets.
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
            end else begin
                do_cycle($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 30,
                         rnd_addr(), {$urandom, $urandom}, $urandom_range(0, 99) < 45,
                         {$urandom, $urandom});
            end
        end
        do_cycle(1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 64'h0);
        @(negedge clk);
        @(negedge clk);
        #4;
        check("writes_outstanding", 128'(wr_q.size()), 128'(0));
        check("loads_outstanding", 128'(ld_q.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
